// File: rtl/tinyenc_if.sv
// tinyenc_if: plaintext/ciphertext valid-ready streams plus the APB config port.
interface tinyenc_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    modport slave (
        input  in_valid, in_data, out_ready, psel, penable, pwrite, paddr, pwdata,
        output in_ready, out_valid, out_data, prdata, pready
    );
    modport master (
        output in_valid, in_data, out_ready, psel, penable, pwrite, paddr, pwdata,
        input  in_ready, out_valid, out_data, prdata, pready
    );
endinterface

// File: rtl/tinyenc.sv
// tinyenc: iterative 32-bit TEA-variant encryptor (16-bit halves), one round per cycle,
// with APB-programmed key, delta, round count and enable.
module tinyenc #(
    parameter logic [63:0] KEY   = 64'h816fc52b09e74da3,
    parameter logic [15:0] DELTA = 16'h1,
    parameter int          SHL   = 4,
    parameter int          SHR   = 5
) (
    input logic       clk,
    input logic       prstb,
    tinyenc_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state, state_n;
    logic [63:0] key;
    logic [15:0] delta;
    logic [2:0]  round;
    logic        enable;
    logic [15:0] blkcnt;
    logic [7:0]  cnt;
    logic [15:0] x, y, sum;
    logic [15:0] sum_n, x_n, y_n;
    logic        out_valid;
    logic [31:0] out_data;
    logic [31:0] prdata;
    logic [31:0] rdata;
    logic        busy, accept, done, cfg_addr, wr;

    function automatic logic [15:0] f(input logic [15:0] v, ka, kb, s);
        return ((v << SHL) + ka) ^ (v + s) ^ ((v >> SHR) + kb);
    endfunction

    assign sum_n = sum + delta;
    assign x_n   = x + f(y, key[15:0], key[31:16], sum_n);
    assign y_n   = y + f(x_n, key[47:32], key[63:48], sum_n);

    assign busy     = state == RUN;
    assign done     = busy && cnt == 8'd1 && enable;
    assign accept   = bus.in_valid && bus.in_ready;
    assign cfg_addr = bus.paddr == 32'h0 || bus.paddr == 32'h4 || bus.paddr == 32'h8 || bus.paddr == 32'hC;
    // Config writes wait out the running block so it never sees a changed key/delta/round.
    assign bus.pready   = !(bus.psel && bus.pwrite && busy && cfg_addr);
    assign wr           = bus.psel && bus.penable && bus.pwrite && bus.pready;
    assign bus.in_ready = enable && state == IDLE && (!out_valid || bus.out_ready);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.prdata    = prdata;

    always_ff @(posedge clk or negedge prstb)
        if (!prstb) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        if (!enable)
            state_n = IDLE;
        else if (state == IDLE)
            state_n = accept ? RUN : IDLE;
        else if (cnt == 8'd1)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge prstb)
        if (!prstb) begin
            cnt       <= '0;
            x         <= '0;
            y         <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!enable) begin
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (bus.out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                {y, x} <= bus.in_data;
                sum    <= '0;
                cnt    <= 8'd1 << round;
            end else if (busy) begin
                sum <= sum_n;
                x   <= x_n;
                y   <= y_n;
                cnt <= cnt - 8'd1;
                if (cnt == 8'd1) begin
                    out_valid <= 1'b1;
                    out_data  <= {y_n, x_n};
                end
            end
        end

    always_comb
        rdata = bus.paddr == 32'h0  ? key[31:0] :
                bus.paddr == 32'h4  ? key[63:32] :
                bus.paddr == 32'h8  ? {16'h0, delta} :
                bus.paddr == 32'hC  ? {27'h0, busy, enable, round} :
                bus.paddr == 32'h10 ? {16'h0, blkcnt} : 32'h0;

    always_ff @(posedge clk or negedge prstb)
        if (!prstb) begin
            key    <= KEY;
            delta  <= DELTA;
            round  <= '0;
            enable <= 1'b1;
            blkcnt <= '0;
            prdata <= '0;
        end else begin
            if (bus.psel)
                prdata <= rdata;
            if (wr && bus.paddr == 32'h0)
                key[31:0] <= bus.pwdata;
            if (wr && bus.paddr == 32'h4)
                key[63:32] <= bus.pwdata;
            if (wr && bus.paddr == 32'h8)
                delta <= bus.pwdata[15:0];
            if (wr && bus.paddr == 32'hC) begin
                round  <= bus.pwdata[2:0];
                enable <= bus.pwdata[3];
            end
            // A clearing write beats a same-cycle completion.
            blkcnt <= (wr && bus.paddr == 32'h10) ? 16'h0 : done ? blkcnt + 16'h1 : blkcnt;
        end
endmodule

// File: tb/tb_tinyenc.sv
// tb_tinyenc: directed stimulus with a queue scoreboard and an independent output monitor.
module tb_tinyenc;
    logic clk = 1'b0;
    logic prstb = 1'b0;
    tinyenc_if bus();
    tinyenc dut (.clk(clk), .prstb(prstb), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] plain;
        logic [31:0] exp;
        logic [63:0] key;
        logic [15:0] delta;
        int          n;
        int          acc;
    } item_t;
    item_t q[$];

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int last_acc = 0;
    bit mon_en = 1'b1;
    bit pv = 1'b0;
    logic [63:0] key_s = 64'h816fc52b09e74da3;
    logic [15:0] delta_s = 16'h1;
    int rnd_s = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fm(input logic [15:0] v, ka, kb, s);
        logic [15:0] a, b, c;
        a = (v << 4) + ka;
        b = v + s;
        c = (v >> 5) + kb;
        return a ^ b ^ c;
    endfunction

    function automatic logic [31:0] enc(input logic [31:0] p, input logic [63:0] k, input logic [15:0] d, input int n);
        logic [15:0] y, x, s;
        {y, x} = p;
        s = 16'h0;
        for (int i = 0; i < n; i++) begin
            s = s + d;
            x = x + fm(y, k[15:0], k[31:16], s);
            y = y + fm(x, k[47:32], k[63:48], s);
        end
        return {y, x};
    endfunction

    function automatic logic [31:0] dec(input logic [31:0] c, input logic [63:0] k, input logic [15:0] d, input int n);
        logic [15:0] y, x, s;
        {y, x} = c;
        for (int i = n; i >= 1; i--) begin
            s = d * 16'(i);
            y = y - fm(x, k[47:32], k[63:48], s);
            x = x - fm(y, k[15:0], k[31:16], s);
        end
        return {y, x};
    endfunction

    // Monitor: latency on the rising edge of out_valid, data and round trip on each handshake.
    always @(negedge clk) begin
        if (mon_en && bus.out_valid && !pv) begin
            if (q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
            else chk("latency", 32'(cyc - q[0].acc), 32'(q[0].n));
        end
        if (mon_en && bus.out_valid && bus.out_ready && q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            chk("out_data", bus.out_data, it.exp);
            chk("round_trip", dec(bus.out_data, it.key, it.delta, it.n), it.plain);
        end
        pv = bus.out_valid;
    end

    task automatic send(input logic [31:0] d, input logic [31:0] e, input bit push);
        int w;
        item_t it;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 1000) begin
            w++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        last_acc = cyc;
        bus.in_valid = 1'b0;
        it.plain = d;
        it.exp = e;
        it.key = key_s;
        it.delta = delta_s;
        it.n = 1 << rnd_s;
        it.acc = cyc;
        if (push) q.push_back(it);
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output int stall);
        @(posedge clk);
        #1;
        bus.psel = 1'b1;
        bus.pwrite = 1'b1;
        bus.penable = 1'b0;
        bus.paddr = a;
        bus.pwdata = d;
        @(posedge clk);
        #1;
        bus.penable = 1'b1;
        stall = 0;
        @(negedge clk);
        while (!bus.pready && stall < 400) begin
            stall++;
            @(negedge clk);
        end
        if (!bus.pready) chk("apb_stall_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int s;
        apb_wr(a, d, s);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
        @(posedge clk);
        #1;
        bus.psel = 1'b1;
        bus.pwrite = 1'b0;
        bus.penable = 1'b0;
        bus.paddr = a;
        @(posedge clk);
        #1;
        bus.penable = 1'b1;
        @(negedge clk);
        chk({name, "_pready"}, 32'(bus.pready), 32'd1);
        @(posedge clk);
        #1;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        chk(name, bus.prdata, e);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() > 0 && w < 2000) begin
            w++;
            @(negedge clk);
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] d, e1;
        int prev, st;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite = 1'b0;
        bus.paddr = '0;
        bus.pwdata = '0;
        #15;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_prdata", bus.prdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 prstb = 1'b1;
        rd("rst_key_lo", 32'h0, 32'h09e74da3);
        rd("rst_key_hi", 32'h4, 32'h816fc52b);
        rd("rst_delta", 32'h8, 32'h1);
        rd("rst_ctrl", 32'hC, 32'h8);
        rd("rst_blkcnt", 32'h10, 32'h0);
        rd("unmapped", 32'h14, 32'h0);

        // Round trip over every round count with back-to-back blocks.
        for (int r = 0; r < 8; r++) begin
            wr(32'hC, 32'(8 | r));
            rnd_s = r;
            for (int b = 0; b < 25; b++) begin
                d = $urandom;
                send(d, enc(d, key_s, delta_s, 1 << r), 1'b1);
                if (b > 0) chk("period", 32'(last_acc - prev), 32'((1 << r) + 1));
                prev = last_acc;
            end
        end
        drain();
        rd("blkcnt_200", 32'h10, 32'd200);

        wr(32'h0, 32'h0);
        wr(32'h4, 32'h0);
        wr(32'h8, 32'h0);
        wr(32'hC, 32'h8);
        key_s = 64'h0;
        delta_s = 16'h0;
        rnd_s = 0;
        send(32'h0001_0000, 32'h0102_0011, 1'b1);
        drain();
        wr(32'h8, 32'h1);
        wr(32'hC, 32'h9);
        delta_s = 16'h1;
        rnd_s = 1;
        send(32'h0001_0000, 32'h3C4B_1291, 1'b1);
        drain();

        // Config write during RUN stalls; the running block keeps the old key.
        wr(32'hC, 32'hF);
        rnd_s = 7;
        send(32'h0001_0000, enc(32'h0001_0000, key_s, delta_s, 128), 1'b1);
        repeat (3) @(negedge clk);
        rd("busy_read", 32'hC, 32'h1F);
        apb_wr(32'h0, 32'h12345678, st);
        chk("stall_long", 32'(st >= 100), 32'd1);
        key_s[31:0] = 32'h12345678;
        drain();
        rd("key_after_stall", 32'h0, 32'h12345678);

        // Backpressure.
        wr(32'hC, 32'h8);
        rnd_s = 0;
        bus.out_ready = 1'b0;
        e1 = enc(32'hDEADBEEF, key_s, delta_s, 1);
        send(32'hDEADBEEF, e1, 1'b1);
        repeat (2) @(negedge clk);
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_data", bus.out_data, e1);
        bus.in_valid = 1'b1;
        bus.in_data = 32'hCAFE_F00D;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_stable", bus.out_data, e1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(32'hCAFE_F00D, enc(32'hCAFE_F00D, key_s, delta_s, 1), 1'b1);
        prev = last_acc;
        send(32'h1234_5678, enc(32'h1234_5678, key_s, delta_s, 1), 1'b1);
        chk("bp_period", 32'(last_acc - prev), 32'd2);
        drain();

        // Soft reset: the enable write waits for the block, then clears out_valid.
        mon_en = 1'b0;
        wr(32'hC, 32'hF);
        rnd_s = 7;
        bus.out_ready = 1'b0;
        send(32'h5555_AAAA, 32'h0, 1'b0);
        wr(32'hC, 32'h7);
        repeat (2) @(negedge clk);
        chk("soft_out_valid", 32'(bus.out_valid), 32'd0);
        chk("soft_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        rd("soft_ctrl", 32'hC, 32'h7);
        rd("soft_key", 32'h0, 32'h12345678);
        rd("soft_blkcnt", 32'h10, 32'd207);
        wr(32'h10, 32'hFFFF_FFFF);
        rd("blkcnt_clear", 32'h10, 32'h0);

        // Hard reset mid-block.
        wr(32'hC, 32'hF);
        send(32'h0BAD_F00D, 32'h0, 1'b0);
        repeat (10) @(negedge clk);
        chk("hard_busy", 32'(dut.state == 1'b1), 32'd1);
        prstb = 1'b0;
        #1;
        chk("hard_out_valid", 32'(bus.out_valid), 32'd0);
        chk("hard_out_data", bus.out_data, 32'h0);
        chk("hard_prdata", bus.prdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 prstb = 1'b1;
        rd("hard_key_lo", 32'h0, 32'h09e74da3);
        rd("hard_key_hi", 32'h4, 32'h816fc52b);
        rd("hard_delta", 32'h8, 32'h1);
        rd("hard_ctrl", 32'hC, 32'h8);
        chk("hard_out_valid_after", 32'(bus.out_valid), 32'd0);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
